// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule: emits one 32-bit word per clock (w[0]..w[43]) and keeps the
// full schedule in a local word file with a combinational read port for the round datapath.
module aes_key_expand_seq #(
  parameter int NK     = 4,
  parameter int NWORDS = 44
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NK*32-1:0] key,
  output logic             busy,
  output logic             done,
  output logic             key_ready,
  output logic             word_valid,
  output logic [5:0]       word_idx,
  output logic [31:0]      word_out,
  input  logic [5:0]       rd_idx,
  output logic [31:0]      rd_word
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_EXPAND = 2'd2;
  localparam logic [5:0] LAST_IDX = 6'(NWORDS - 1);
  localparam logic [5:0] END_IDX  = 6'(NWORDS);

  logic [1:0]  state;
  logic [5:0]  idx;
  logic [31:0] wfile [NWORDS];
  logic [5:0]  prev_i, back_i;
  logic [31:0] prev_w, back_w, t_rot, t_sub, new_w;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box = affine(x^254); x^254 is the GF(2^8) inverse and maps 0 to 0.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] acc, sq, inv;
    acc = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    inv = acc;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  assign prev_i = idx - 6'd1;
  assign back_i = idx - 6'd4;
  assign prev_w = wfile[prev_i];
  assign back_w = wfile[back_i];

  always_comb begin
    t_rot = {prev_w[23:0], prev_w[31:24]};
    t_sub = subword(t_rot) ^ rcon(idx[5:2]);
    new_w = back_w ^ ((idx[1:0] == 2'd0) ? t_sub : prev_w);
  end

  assign rd_word = (rd_idx <= LAST_IDX) ? wfile[rd_idx] : 32'h0;

  // After w[43] the FSM spends one more EXPAND cycle (idx==NWORDS) so that word_valid
  // is never high while in IDLE and done lands one cycle after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= 6'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      key_ready  <= 1'b0;
      word_valid <= 1'b0;
      word_idx   <= 6'd0;
      word_out   <= 32'h0;
      for (int i = 0; i < NWORDS; i++) wfile[i] <= 32'h0;
    end else begin
      done       <= 1'b0;
      word_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            wfile[0]   <= key[127:96];
            wfile[1]   <= key[95:64];
            wfile[2]   <= key[63:32];
            wfile[3]   <= key[31:0];
            busy       <= 1'b1;
            key_ready  <= 1'b0;
            word_valid <= 1'b1;
            word_idx   <= 6'd0;
            word_out   <= key[127:96];
            idx        <= 6'd1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          word_valid <= 1'b1;
          word_idx   <= idx;
          word_out   <= wfile[idx];
          idx        <= idx + 6'd1;
          if (idx == 6'd3) state <= S_EXPAND;
        end
        S_EXPAND: begin
          if (idx == END_IDX) begin
            state     <= S_IDLE;
            idx       <= 6'd0;
            busy      <= 1'b0;
            done      <= 1'b1;
            key_ready <= 1'b1;
          end else begin
            wfile[idx] <= new_w;
            word_valid <= 1'b1;
            word_idx   <= idx;
            word_out   <= new_w;
            idx        <= idx + 6'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed testbench for aes_key_expand_seq: FIPS-197 and all-zero keys, busy/start
// interaction, mid-run reset, start-in-done-cycle and the word-file read port.
module tb_aes_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic         busy, done, key_ready, word_valid;
  logic [5:0]   word_idx;
  logic [31:0]  word_out;
  logic [5:0]   rd_idx;
  logic [31:0]  rd_word;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] got   [44];
  logic [31:0] exp_w [44];

  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KALT = 128'hffeeddccbbaa99887766554433221100;

  always #5 clk = ~clk;

  aes_key_expand_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key),
    .busy(busy), .done(done), .key_ready(key_ready),
    .word_valid(word_valid), .word_idx(word_idx), .word_out(word_out),
    .rd_idx(rd_idx), .rd_word(rd_word)
  );

  // Reference GF(2^8) multiply: carry-less product, then reduce by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv, c, s;
    inv = 8'h00;
    c   = 8'h63;
    for (int y = 1; y < 256; y++) if (gmul_ref(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
    return s;
  endfunction

  task automatic build_model(input logic [127:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    exp_w[0] = k[127:96];
    exp_w[1] = k[95:64];
    exp_w[2] = k[63:32];
    exp_w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = exp_w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
        t = t ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      exp_w[i] = exp_w[i - 4] ^ t;
    end
  endtask

  task automatic start_now(input logic [127:0] k);
    key   = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic start_run(input logic [127:0] k);
    @(negedge clk);
    start_now(k);
  endtask

  // Samples one negedge per cycle after the start edge; c counts cycles after that edge.
  task automatic capture(input int max_c, input int inj_at, input logic [127:0] inj_key,
                         output int done_at, output int busy_cnt, output int valid_cnt,
                         output logic kr0);
    done_at = -1; busy_cnt = 0; valid_cnt = 0; kr0 = 1'b1;
    for (int i = 0; i < 44; i++) got[i] = 32'hdeadbeef;
    for (int c = 0; c < max_c; c++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (c == 0) kr0 = key_ready;
      if (word_valid && word_idx < 44) begin got[word_idx] = word_out; valid_cnt++; end
      if (busy) busy_cnt++;
      if (c == inj_at) begin start = 1'b1; key = inj_key; end
      if (done) begin done_at = c; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; key = '0; rd_idx = 6'd0;
    #12;
    n_tests++;
    if ({busy, done, key_ready, word_valid, word_idx, word_out} !== 41'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b kr=%b vld=%b idx=%0d out=%h, want all 0",
               busy, done, key_ready, word_valid, word_idx, word_out);
    end
    rd_idx = 6'd7; #1;
    n_tests++;
    if (rd_word !== 32'h0) begin n_fail++; $display("FAIL reset_rd_word: got %h want 0", rd_word); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fips_key;
    int d, b, v; logic kr;
    build_model(K1);
    start_run(K1);
    capture(60, -1, '0, d, b, v, kr);
    n_tests++; if (d !== 44) begin n_fail++; $display("FAIL fips_done_at: got %0d want 44", d); end
    n_tests++; if (b !== 44) begin n_fail++; $display("FAIL fips_busy_cycles: got %0d want 44", b); end
    n_tests++; if (v !== 44) begin n_fail++; $display("FAIL fips_valid_words: got %0d want 44", v); end
    n_tests++; if (kr !== 1'b0) begin n_fail++; $display("FAIL fips_kr_during_run: got %b want 0", kr); end
    n_tests++; if (got[4] !== 32'ha0fafe17) begin n_fail++; $display("FAIL fips_w4: got %h want a0fafe17", got[4]); end
    n_tests++; if (got[5] !== 32'h88542cb1) begin n_fail++; $display("FAIL fips_w5: got %h want 88542cb1", got[5]); end
    n_tests++; if (got[40] !== 32'hd014f9a8) begin n_fail++; $display("FAIL fips_w40: got %h want d014f9a8", got[40]); end
    n_tests++; if (got[41] !== 32'hc9ee2589) begin n_fail++; $display("FAIL fips_w41: got %h want c9ee2589", got[41]); end
    n_tests++; if (got[42] !== 32'he13f0cc8) begin n_fail++; $display("FAIL fips_w42: got %h want e13f0cc8", got[42]); end
    n_tests++; if (got[43] !== 32'hb6630ca6) begin n_fail++; $display("FAIL fips_w43: got %h want b6630ca6", got[43]); end
    for (int i = 0; i < 44; i++) begin
      n_tests++;
      if (got[i] !== exp_w[i]) begin n_fail++; $display("FAIL fips_w%0d: got %h want %h", i, got[i], exp_w[i]); end
    end
    n_tests++;
    if ({key_ready, busy, word_valid} !== 3'b100) begin
      n_fail++; $display("FAIL fips_done_cycle_flags: got kr/busy/vld=%b want 100", {key_ready, busy, word_valid});
    end
    @(negedge clk);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL fips_done_single: got %b want 0", done); end
  endtask

  task automatic test_rd_sweep;
    for (int i = 0; i < 64; i++) begin
      rd_idx = 6'(i);
      #1;
      n_tests++;
      if (i <= 43 && rd_word !== exp_w[i]) begin
        n_fail++; $display("FAIL rd_word[%0d]: got %h want %h", i, rd_word, exp_w[i]);
      end else if (i > 43 && rd_word !== 32'h0) begin
        n_fail++; $display("FAIL rd_word[%0d]: got %h want 0", i, rd_word);
      end
    end
    rd_idx = 6'd0;
  endtask

  task automatic check_zero_schedule(input string tag, input int d);
    n_tests++; if (d !== 44) begin n_fail++; $display("FAIL %s_done_at: got %0d want 44", tag, d); end
    for (int i = 4; i < 8; i++) begin
      n_tests++;
      if (got[i] !== 32'h62636363) begin n_fail++; $display("FAIL %s_w%0d: got %h want 62636363", tag, i, got[i]); end
    end
    n_tests++; if (got[40] !== 32'hb4ef5bcb) begin n_fail++; $display("FAIL %s_w40: got %h want b4ef5bcb", tag, got[40]); end
    n_tests++; if (got[43] !== 32'h6f8f188e) begin n_fail++; $display("FAIL %s_w43: got %h want 6f8f188e", tag, got[43]); end
  endtask

  task automatic test_zero_key;
    int d, b, v; logic kr;
    build_model('0);
    start_run('0);
    capture(60, -1, '0, d, b, v, kr);
    check_zero_schedule("zero", d);
    for (int i = 0; i < 44; i++) begin
      n_tests++;
      if (got[i] !== exp_w[i]) begin n_fail++; $display("FAIL zero_w%0d: got %h want %h", i, got[i], exp_w[i]); end
    end
  endtask

  task automatic test_start_while_busy;
    int d, b, v; logic kr;
    build_model(K1);
    start_run(K1);
    capture(60, 10, KALT, d, b, v, kr);
    n_tests++; if (d !== 44) begin n_fail++; $display("FAIL busy_start_done_at: got %0d want 44", d); end
    n_tests++; if (b !== 44) begin n_fail++; $display("FAIL busy_start_busy_cycles: got %0d want 44", b); end
    n_tests++; if (got[43] !== 32'hb6630ca6) begin n_fail++; $display("FAIL busy_start_w43: got %h want b6630ca6", got[43]); end
    for (int i = 0; i < 44; i++) begin
      n_tests++;
      if (got[i] !== exp_w[i]) begin n_fail++; $display("FAIL busy_start_w%0d: got %h want %h", i, got[i], exp_w[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int d, b, v, done_seen; logic kr;
    build_model(K1);
    start_run(K1);
    capture(21, -1, '0, d, b, v, kr);
    n_tests++;
    if (word_valid !== 1'b1 || word_idx !== 6'd20 || got[20] !== exp_w[20]) begin
      n_fail++; $display("FAIL midrst_at_w20: got vld=%b idx=%0d w=%h want 1/20/%h", word_valid, word_idx, got[20], exp_w[20]);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, key_ready, word_valid, word_idx, word_out} !== 41'h0) begin
      n_fail++; $display("FAIL midrst_outputs: got busy=%b done=%b kr=%b vld=%b idx=%0d out=%h, want all 0",
                         busy, done, key_ready, word_valid, word_idx, word_out);
    end
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 3) rst_n = 1'b1;
      if (done) done_seen++;
    end
    n_tests++; if (done_seen != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); end
    rd_idx = 6'd5; #1;
    n_tests++;
    if (key_ready !== 1'b0 || rd_word !== 32'h0) begin
      n_fail++; $display("FAIL midrst_cleared: got kr=%b w5=%h want 0/0", key_ready, rd_word);
    end
    rd_idx = 6'd0;
    start_run(K1);
    capture(60, -1, '0, d, b, v, kr);
    n_tests++; if (d !== 44) begin n_fail++; $display("FAIL midrst_restart_done_at: got %0d want 44", d); end
    n_tests++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_restart_kr: got %b want 1", key_ready); end
    for (int i = 0; i < 44; i++) begin
      n_tests++;
      if (got[i] !== exp_w[i]) begin n_fail++; $display("FAIL midrst_restart_w%0d: got %h want %h", i, got[i], exp_w[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int d, b, v; logic kr;
    start_run(K1);
    capture(60, -1, '0, d, b, v, kr);
    n_tests++;
    if (done !== 1'b1 || key_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first_done: got done=%b kr=%b want 1/1", done, key_ready);
    end
    build_model('0);
    start_now('0);
    capture(60, -1, '0, d, b, v, kr);
    n_tests++; if (kr !== 1'b0) begin n_fail++; $display("FAIL b2b_kr_dropped: got %b want 0", kr); end
    check_zero_schedule("b2b", d);
    n_tests++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_kr_final: got %b want 1", key_ready); end
    rd_idx = 6'd43; #1;
    n_tests++; if (rd_word !== exp_w[43]) begin n_fail++; $display("FAIL b2b_rd_w43: got %h want %h", rd_word, exp_w[43]); end
    rd_idx = 6'd0;
  endtask

  initial begin
    test_reset();
    test_fips_key();
    test_rd_sweep();
    test_zero_key();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
